// File: rtl/lgn_pixel_feeder.sv
// Streams one frame of pixel words onto the inference core's strobed pixel bus.
// After the last word it waits a fixed settle time, then captures the core result for a valid/ready consumer.
module lgn_pixel_feeder #(
    parameter int WORDS  = 98,
    parameter int DATA_W = 8,
    parameter int RES_W  = 16,
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] pix_out,
    output logic              pix_we_n,
    input  logic [RES_W-1:0]  lgn_in,
    output logic [RES_W-1:0]  res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic [7:0]        frame_cnt
);

    localparam int WC_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SC_W = $clog2(SETTLE + 1);
    localparam logic [WC_W-1:0] WORD_LAST   = WC_W'(WORDS - 1);
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_RESULT
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic [SC_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [DATA_W-1:0] pix_out_q, pix_out_d;
    logic              pix_we_n_q, pix_we_n_d;
    logic [RES_W-1:0]  res_data_q, res_data_d;
    logic              res_valid_q, res_valid_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              s_ready_q, s_ready_d;
    logic              wr_hs;
    logic              rd_hs;

    assign wr_hs = s_valid && s_ready_q;
    assign rd_hs = res_valid_q && res_ready;

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        settle_cnt_d = settle_cnt_q;
        pix_out_d    = pix_out_q;
        pix_we_n_d   = 1'b1;
        res_data_d   = res_data_q;
        res_valid_d  = res_valid_q;
        frame_cnt_d  = frame_cnt_q;
        if (flush) begin
            // Abort beats any handshake in the same cycle: nothing written, nothing counted.
            state_d      = ST_LOAD;
            word_cnt_d   = '0;
            settle_cnt_d = '0;
            res_valid_d  = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (wr_hs) begin
                        pix_out_d  = s_data;
                        pix_we_n_d = 1'b0;
                        if (word_cnt_q == WORD_LAST) begin
                            word_cnt_d   = '0;
                            settle_cnt_d = '0;
                            state_d      = ST_SETTLE;
                        end else begin
                            word_cnt_d = word_cnt_q + WC_W'(1);
                        end
                    end
                end
                ST_SETTLE: begin
                    settle_cnt_d = settle_cnt_q + SC_W'(1);
                    if (settle_cnt_q == SETTLE_LAST) begin
                        res_data_d  = lgn_in;
                        res_valid_d = 1'b1;
                        state_d     = ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (rd_hs) begin
                        res_valid_d = 1'b0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        state_d     = ST_LOAD;
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end
        // Registered from the next state so ready never depends on this cycle's inputs.
        s_ready_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            word_cnt_q   <= '0;
            settle_cnt_q <= '0;
            pix_out_q    <= '0;
            pix_we_n_q   <= 1'b1;
            res_data_q   <= '0;
            res_valid_q  <= 1'b0;
            frame_cnt_q  <= '0;
            s_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            pix_out_q    <= pix_out_d;
            pix_we_n_q   <= pix_we_n_d;
            res_data_q   <= res_data_d;
            res_valid_q  <= res_valid_d;
            frame_cnt_q  <= frame_cnt_d;
            s_ready_q    <= s_ready_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign pix_out   = pix_out_q;
    assign pix_we_n  = pix_we_n_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = (state_q != ST_LOAD) || (word_cnt_q != '0);

endmodule

// File: tb/tb_lgn_pixel_feeder.sv
// Directed bench for lgn_pixel_feeder: frames, gaps, backpressure, flush, reset and frame counter wrap.
module tb_lgn_pixel_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  pix_out;
    logic        pix_we_n;
    logic [15:0] lgn_in = '0;
    logic [15:0] res_data;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic        busy;
    logic [7:0]  frame_cnt;

    int tests = 0;
    int fails = 0;

    logic [7:0] pix_q[$];
    int         res_hs_cnt = 0;
    bit         res_seen = 1'b0;

    lgn_pixel_feeder #(.WORDS(98), .DATA_W(8), .RES_W(16), .SETTLE(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .pix_out(pix_out), .pix_we_n(pix_we_n),
        .lgn_in(lgn_in), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Each strobe is low for exactly one full cycle, so it spans exactly one falling edge.
    always @(negedge clk) begin
        if (pix_we_n === 1'b0) pix_q.push_back(pix_out);
        if (res_valid === 1'b1) res_seen = 1'b1;
        if (res_valid === 1'b1 && res_ready === 1'b1 && flush === 1'b0 && rst === 1'b0)
            res_hs_cnt++;
    end

    task automatic feed(input int n, input int base, input bit gaps);
        for (int i = 0; i < n; i++) begin
            s_data  = 8'(base + i);
            s_valid = 1'b1;
            @(posedge clk); #1;
            if (gaps) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (res_valid === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (s_ready !== 1'b0 || pix_out !== 8'h00 || pix_we_n !== 1'b1 || res_data !== 16'h0 ||
            res_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'h0) begin
            fails++;
            $display("FAIL reset_values: s_ready=%b pix_out=%h we_n=%b res_data=%h res_valid=%b busy=%b frame_cnt=%0d, required 0 00 1 0000 0 0 0",
                     s_ready, pix_out, pix_we_n, res_data, res_valid, busy, frame_cnt);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (s_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: s_ready=%b required 1", s_ready);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_full_frame();
        int cyc;
        bit ok;
        pix_q.delete();
        lgn_in = 16'hBEEF;
        res_ready = 1'b1;
        feed(98, 0, 1'b0);
        tests++;
        if (s_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL full_settle_flags: s_ready=%b busy=%b required 0 1", s_ready, busy);
        end
        wait_valid(cyc);
        tests++;
        if (cyc !== 4 || res_data !== 16'hBEEF) begin
            fails++;
            $display("FAIL full_result: edges=%0d data=%h required 4 BEEF", cyc, res_data);
        end
        @(posedge clk); #1;
        tests++;
        if (frame_cnt !== 8'd1 || res_valid !== 1'b0 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL full_done: frame_cnt=%0d res_valid=%b s_ready=%b required 1 0 1",
                     frame_cnt, res_valid, s_ready);
        end
        ok = (pix_q.size() == 98);
        for (int i = 0; i < pix_q.size() && ok; i++) if (pix_q[i] !== 8'(i)) ok = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL full_words: strobes=%0d required 98 in order 00..61", pix_q.size());
        end
        $display("[TB] test_full_frame done");
    endtask

    task automatic test_gaps();
        int cyc;
        bit ok;
        pix_q.delete();
        lgn_in = 16'hBEEF;
        feed(98, 8'h10, 1'b1);
        wait_valid(cyc);
        tests++;
        if (cyc !== 3 || res_data !== 16'hBEEF) begin
            fails++;
            $display("FAIL gaps_result: edges_after_196=%0d data=%h required 3 BEEF", cyc, res_data);
        end
        ok = (pix_q.size() == 98);
        for (int i = 0; i < pix_q.size() && ok; i++) if (pix_q[i] !== 8'(8'h10 + i)) ok = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL gaps_words: strobes=%0d required 98 in order 10..71", pix_q.size());
        end
        @(posedge clk); #1;
        tests++;
        if (frame_cnt !== 8'd2) begin
            fails++;
            $display("FAIL gaps_frame_cnt: got %0d required 2", frame_cnt);
        end
        $display("[TB] test_gaps done");
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad = 0;
        lgn_in = 16'hBEEF;
        res_ready = 1'b0;
        feed(98, 0, 1'b0);
        wait_valid(cyc);
        tests++;
        if (cyc !== 4) begin
            fails++;
            $display("FAIL bp_latency: edges=%0d required 4", cyc);
        end
        lgn_in = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (res_data !== 16'hBEEF || res_valid !== 1'b1 || s_ready !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_hold: bad_cycles=%0d data=%h required 0 BEEF", bad, res_data);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (res_valid !== 1'b0 || s_ready !== 1'b1 || frame_cnt !== 8'd3) begin
            fails++;
            $display("FAIL bp_release: res_valid=%b s_ready=%b frame_cnt=%0d required 0 1 3",
                     res_valid, s_ready, frame_cnt);
        end
        $display("[TB] test_backpressure done");
    endtask

    task automatic test_flush();
        int cyc;
        int hs0;
        pix_q.delete();
        lgn_in = 16'hCAFE;
        feed(50, 0, 1'b0);
        s_data  = 8'd50;
        s_valid = 1'b1;
        flush   = 1'b1;
        @(posedge clk); #1;
        flush   = 1'b0;
        s_valid = 1'b0;
        tests++;
        if (pix_we_n !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_state: we_n=%b busy=%b s_ready=%b required 1 0 1", pix_we_n, busy, s_ready);
        end
        @(negedge clk);
        tests++;
        if (pix_q.size() != 50) begin
            fails++;
            $display("FAIL flush_no_strobe: strobes=%0d required 50", pix_q.size());
        end
        #4;
        hs0 = res_hs_cnt;
        feed(98, 8'h80, 1'b0);
        wait_valid(cyc);
        tests++;
        if (cyc !== 4 || res_data !== 16'hCAFE) begin
            fails++;
            $display("FAIL flush_frame: edges=%0d data=%h required 4 CAFE", cyc, res_data);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (res_hs_cnt - hs0 != 1 || frame_cnt !== 8'd4) begin
            fails++;
            $display("FAIL flush_count: results=%0d frame_cnt=%0d required 1 4", res_hs_cnt - hs0, frame_cnt);
        end
        $display("[TB] test_flush done");
    endtask

    task automatic test_reset_mid_settle();
        int cyc;
        lgn_in = 16'h5A5A;
        feed(98, 0, 1'b0);
        res_seen = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (s_ready !== 1'b0 || pix_out !== 8'h00 || pix_we_n !== 1'b1 || res_data !== 16'h0 ||
            res_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'h0) begin
            fails++;
            $display("FAIL rst_settle_values: s_ready=%b pix_out=%h we_n=%b res_data=%h res_valid=%b busy=%b frame_cnt=%0d",
                     s_ready, pix_out, pix_we_n, res_data, res_valid, busy, frame_cnt);
        end
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        tests++;
        if (res_seen || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_settle_quiet: res_seen=%b s_ready=%b required 0 1", res_seen, s_ready);
        end
        feed(98, 0, 1'b0);
        wait_valid(cyc);
        @(posedge clk); #1;
        tests++;
        if (cyc !== 4 || frame_cnt !== 8'd1) begin
            fails++;
            $display("FAIL rst_settle_next: edges=%0d frame_cnt=%0d required 4 1", cyc, frame_cnt);
        end
        $display("[TB] test_reset_mid_settle done");
    endtask

    task automatic test_wrap();
        int cyc;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        res_ready = 1'b1;
        for (int f = 0; f < 256; f++) begin
            lgn_in = 16'(f);
            feed(98, f, 1'b0);
            wait_valid(cyc);
            tests++;
            if (cyc !== 4 || res_data !== 16'(f)) begin
                fails++;
                $display("FAIL wrap_frame_%0d: edges=%0d data=%h required 4 %h", f, cyc, res_data, 16'(f));
            end
            @(posedge clk); #1;
            if (f == 254) begin
                tests++;
                if (frame_cnt !== 8'd255) begin
                    fails++;
                    $display("FAIL wrap_255: frame_cnt=%0d required 255", frame_cnt);
                end
            end
        end
        tests++;
        if (frame_cnt !== 8'd0) begin
            fails++;
            $display("FAIL wrap_zero: frame_cnt=%0d required 0", frame_cnt);
        end
        $display("[TB] test_wrap done");
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gaps();
        test_backpressure();
        test_flush();
        test_reset_mid_settle();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lgn_pixel_feeder.md
# lgn_pixel_feeder

Host-side frame writer for the logic-gate-network inference core. It accepts image words over a valid/ready stream and drives them onto the core's 8-bit pixel bus with the core's active-low write strobe, one word per strobe. After a full frame it waits a fixed settle time, captures the core's 16-bit result bus and presents it on a valid/ready result port. It sits on the FPGA/tester side of the chip pads, or in the top-level bench, opposite the chip's pixel-input and result-output pins.

## Interface

Parameters:
- `WORDS`, 98, pixel words per frame (784 binarized pixels / 8); must be ≥ 2.
- `DATA_W`, 8, pixel bus width.
- `RES_W`, 16, result bus width.
- `SETTLE`, 4, cycles from the last write strobe to result capture; must be ≥ 1.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `flush`  in  1  synchronous abort; discards the partial frame or the pending result.
- `s_data`  in  DATA_W  pixel word.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  feeder accepts a word this cycle.
- `pix_out`  out  DATA_W  to the core's pixel inputs; registered.
- `pix_we_n`  out  1  to the core's write-enable pin, active low; registered.
- `lgn_in`  in  RES_W  from the core's result outputs.
- `res_data`  out  RES_W  captured result.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumer ready.
- `busy`  out  1  high in SETTLE or RESULT, or when the word count is nonzero.
- `frame_cnt`  out  8  completed frames (result handshakes); wraps 255→0.

## Operation

- States: LOAD, SETTLE, RESULT. After reset the state is LOAD.
- LOAD:
  - `s_ready` = 1.
  - On a handshake (`s_valid && s_ready`): `pix_out` ← `s_data`, `pix_we_n` ← 0 for exactly one cycle, word count increments.
  - On the handshake with count = WORDS-1: count ← 0, settle counter ← 0, go to SETTLE.
- SETTLE:
  - `s_ready` = 0.
  - The settle counter increments each cycle.
  - When it reaches SETTLE-1: `res_data` ← `lgn_in`, `res_valid` ← 1, go to RESULT.
- RESULT:
  - `s_ready` = 0.
  - `res_data` and `res_valid` are held stable until `res_valid && res_ready`.
  - On that handshake: `res_valid` ← 0, `frame_cnt` increments, go to LOAD.
- Outside a write cycle, `pix_we_n` = 1 and `pix_out` holds its last written value.
- `flush`:
  - Returns to LOAD with the word count and settle counter cleared and `res_valid` ← 0.
  - `frame_cnt` is unchanged.
  - `flush` wins over a simultaneous stream or result handshake: the word is not written (`pix_we_n` stays 1), and the result is not counted.
- Reset values: `s_ready` 0 in the reset cycle, then 1. `pix_out` 0, `pix_we_n` 1, `res_data` 0, `res_valid` 0, `busy` 0, `frame_cnt` 0.
- Reset mid-frame or mid-settle discards all progress. No partial strobe is emitted after reset is asserted.

## Timing

- Write latency:
  - Handshake sampled at edge N → `pix_out`/`pix_we_n`=0 valid from edge N to edge N+1.
  - The core samples the word at edge N+1.
- Maximum throughput is one word per cycle, with back-to-back strobes allowed. `s_valid` gaps produce `pix_we_n` = 1 cycles.
- Last-word handshake at edge N:
  - SETTLE from edge N.
  - `lgn_in` captured at edge N+SETTLE.
  - `res_valid` high from edge N+SETTLE.
  - The core therefore has SETTLE-1 full cycles after its final write edge.
- Result handshake at edge M → `s_ready` = 1 from edge M.
- Minimum frame period is WORDS + SETTLE + 1 cycles with `res_ready` tied high.
- `s_ready` is a function of state only. It has no combinational path from `s_valid` or `res_ready`.

## Test plan

- Full frame:
  - Stimulus: WORDS=98, SETTLE=4, 98 back-to-back words 0x00..0x61, `lgn_in`=0xBEEF, `res_ready`=1.
  - Response: exactly 98 `pix_we_n` low cycles with `pix_out` matching in order; `res_data`=0xBEEF exactly 4 edges after the last handshake; `frame_cnt`=1.
- Stream gaps:
  - Stimulus: `s_valid` toggles every other cycle.
  - Response: strobes only on accepted cycles; no duplicated or dropped words; same result after 196 cycles.
- Result backpressure:
  - Stimulus: `res_ready`=0 for 10 cycles after `res_valid`, with `lgn_in` changed to 0x1234 meanwhile.
  - Response: `res_data` stays 0xBEEF; `s_ready`=0 throughout; LOAD resumes the edge after the handshake.
- Flush:
  - Stimulus: `flush` asserted together with the handshake of word 50, then a clean full frame.
  - Response: word 50 is not strobed; exactly one result; `frame_cnt` increments once.
- Reset:
  - Stimulus: `rst` asserted in SETTLE cycle 2.
  - Response: `res_valid` never rises; all outputs at reset values; the next 98-word frame completes normally.
- Counter wrap:
  - Stimulus: 256 frames with `res_ready`=1 and `lgn_in` = frame index.
  - Response: each `res_data` matches its frame index; `frame_cnt` reads 0 after the 256th.
